// File: rtl/kugelblitz_frame_patch_if.sv
// AXI-stream bundle shared by the input and output sides of the frame patcher.
interface kugelblitz_frame_patch_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/kugelblitz_frame_patch.sv
// Overwrites one configurable byte per frame in a 512-bit AXI stream; output
// register plus skid register keep full throughput with a flop-driven tready.
module kugelblitz_frame_patch #(
  parameter int DATA_WIDTH   = 512,
  parameter int KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int USER_WIDTH   = 1,
  parameter int OFFSET_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  kugelblitz_frame_patch_if.slave  s_axis,
  kugelblitz_frame_patch_if.master m_axis,
  input  logic                    cfg_enable,
  input  logic [OFFSET_WIDTH-1:0] cfg_offset,
  input  logic [7:0]              cfg_data,
  output logic [31:0]             stat_frame_count,
  output logic [31:0]             stat_patch_count
);
  localparam int CNT_W = OFFSET_WIDTH-6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (DATA_WIDTH != 512) begin : g_bad_data_width
    $error("kugelblitz_frame_patch: only DATA_WIDTH=512 is supported");
  end
  if (KEEP_WIDTH*8 != DATA_WIDTH) begin : g_bad_keep_width
    $error("kugelblitz_frame_patch: KEEP_WIDTH*8 must equal DATA_WIDTH");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic                  patched;
  } beat_t;

  typedef enum logic {IDLE, FRAME} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    en_q;
  logic [OFFSET_WIDTH-1:0] off_q;
  logic [7:0]              dat_q;

  beat_t out_q, skid_q, in_beat;
  logic  out_vld, skid_vld, skid_vld_nxt, rdy_q, out_free, accept;
  logic [31:0] frame_cnt, patch_cnt;

  assign accept = s_axis.tvalid & rdy_q;

  // First beat of a frame sees the live config; later beats see the latched copy.
  logic                    en_eff;
  logic [OFFSET_WIDTH-1:0] off_eff;
  logic [7:0]              dat_eff;
  logic [5:0]              lane;
  logic [CNT_W-1:0]        tgt_beat;
  logic                    hit;

  assign en_eff   = (state == IDLE) ? cfg_enable : en_q;
  assign off_eff  = (state == IDLE) ? cfg_offset : off_q;
  assign dat_eff  = (state == IDLE) ? cfg_data   : dat_q;
  assign lane     = off_eff[5:0];
  assign tgt_beat = off_eff[OFFSET_WIDTH-1:6];
  assign hit      = en_eff && (beat_cnt == tgt_beat) && (beat_cnt != CNT_MAX) &&
                    s_axis.tkeep[lane];

  logic [KEEP_WIDTH-1:0][7:0] lane_data;
  for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
    assign lane_data[i] = (hit && lane == 6'(i)) ? dat_eff : s_axis.tdata[i*8 +: 8];
  end

  always_comb begin
    in_beat         = '0;
    in_beat.data    = lane_data;
    in_beat.keep    = s_axis.tkeep;
    in_beat.last    = s_axis.tlast;
    in_beat.user    = s_axis.tuser;
    in_beat.patched = hit;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = s_axis.tlast ? IDLE : FRAME;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      en_q     <= 1'b0;
      off_q    <= '0;
      dat_q    <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        en_q  <= cfg_enable;
        off_q <= cfg_offset;
        dat_q <= cfg_data;
      end
      if (s_axis.tlast)              beat_cnt <= '0;
      else if (beat_cnt != CNT_MAX)  beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  // Skid only fills when the output register is stalled; it drains first.
  assign out_free     = ~out_vld | m_axis.tready;
  assign skid_vld_nxt = out_free ? 1'b0 : (skid_vld | accept);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_vld) begin
          out_q   <= skid_q;
          out_vld <= 1'b1;
        end else if (accept) begin
          out_q   <= in_beat;
          out_vld <= 1'b1;
        end else begin
          out_vld <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= in_beat;
      end
      skid_vld <= skid_vld_nxt;
      rdy_q    <= ~skid_vld_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      patch_cnt <= '0;
    end else if (out_vld && m_axis.tready) begin
      if (out_q.last)    frame_cnt <= frame_cnt + 32'd1;
      if (out_q.patched) patch_cnt <= patch_cnt + 32'd1;
    end
  end

  assign s_axis.tready    = rdy_q;
  assign m_axis.tvalid    = out_vld;
  assign m_axis.tdata     = out_q.data;
  assign m_axis.tkeep     = out_q.keep;
  assign m_axis.tlast     = out_q.last;
  assign m_axis.tuser     = out_q.user;
  assign stat_frame_count = frame_cnt;
  assign stat_patch_count = patch_cnt;
endmodule

// File: tb/tb_kugelblitz_frame_patch.sv
// Randomized scoreboard bench for kugelblitz_frame_patch against a frame-level byte-patch model.
module tb_kugelblitz_frame_patch;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 1;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kugelblitz_frame_patch_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_if ();
  kugelblitz_frame_patch_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

  logic          cfg_enable;
  logic [OW-1:0] cfg_offset;
  logic [7:0]    cfg_data;
  logic [31:0]   stat_frame_count, stat_patch_count;

  kugelblitz_frame_patch #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .OFFSET_WIDTH(OW)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis           (s_if.slave),
    .m_axis           (m_if.master),
    .cfg_enable       (cfg_enable),
    .cfg_offset       (cfg_offset),
    .cfg_data         (cfg_data),
    .stat_frame_count (stat_frame_count),
    .stat_patch_count (stat_patch_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
    bit            patched;
    int            acc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0, cyc = 0;
  bit          chk_en = 0, chk_lat = 0, pend = 0;
  int          rdy_mode = 0, pidx = 0;
  logic [31:0] exp_frame = 0, exp_patch = 0;

  // reference model: frame position and config captured at the frame's first beat
  bit         in_frame = 0;
  int         bidx = 0;
  bit         l_en;
  int         l_off;
  logic [7:0] l_dat;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_accept(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                       input logic last, input logic [UW-1:0] u);
    exp_t e;
    if (!in_frame) begin
      l_en = cfg_enable; l_off = int'(cfg_offset); l_dat = cfg_data; bidx = 0;
    end
    e.data = d; e.keep = k; e.last = last; e.user = u; e.acc = cyc;
    e.patched = l_en && (bidx == l_off / 64) && (bidx < 1023) && k[l_off % 64];
    if (e.patched) e.data[(l_off % 64)*8 +: 8] = l_dat;
    q.push_back(e);
    pend = 1;
    if (last) begin
      in_frame = 0; bidx = 0;
    end else begin
      in_frame = 1;
      if (bidx < 1023) bidx++;
    end
  endfunction

  // called at a falling edge; returns at the falling edge after acceptance
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic last,
                      input logic [UW-1:0] u);
    int t = 0;
    s_if.tdata = d; s_if.tkeep = k; s_if.tlast = last; s_if.tuser = u; s_if.tvalid = 1'b1;
    while (!s_if.tready && t < 1000) begin
      @(negedge clk); t++;
    end
    if (!s_if.tready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got tready=0 expected tready=1 within 1000 cycles");
    end else begin
      model_accept(d, k, last, u);
    end
    @(negedge clk);
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit rnd_keep);
    for (int b = 0; b < len; b++)
      send(rnd_data(), rnd_keep ? {$urandom, $urandom} : {KW{1'b1}}, b == len-1, UW'($urandom));
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(negedge clk); t++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats outstanding expected 0", q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata",  m_if.tdata,  0);
    chk("rst_m_tkeep",  m_if.tkeep,  0);
    chk("rst_m_tlast",  m_if.tlast,  0);
    chk("rst_m_tuser",  m_if.tuser,  0);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_frame_cnt", stat_frame_count, 0);
    chk("rst_patch_cnt", stat_patch_count, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    chk("tready_before_edge", s_if.tready, 0);
    @(negedge clk);
    chk("tready_after_edge", s_if.tready, 1);
    chk_en = 1;
  endtask

  // downstream ready generator
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       m_if.tready = 1'b1;
        1:       begin m_if.tready = (pidx % 4 == 0) || (pidx % 4 == 3); pidx++; end
        default: m_if.tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    bit            stall = 0;
    logic [DW-1:0] sd;
    logic [KW-1:0] sk;
    logic          sl;
    int            held;
    exp_t          e;
    forever begin
      @(negedge clk); #1;
      if (!chk_en) begin
        pend = 0; stall = 0;
        continue;
      end
      held = q.size() - (pend ? 1 : 0);
      pend = 0;
      chk("s_tready_occupancy", s_if.tready, held < 2);
      chk("m_tvalid_occupancy", m_if.tvalid, held > 0);
      chk("stat_frame_count", stat_frame_count, exp_frame);
      chk("stat_patch_count", stat_patch_count, exp_patch);
      if (stall && m_if.tvalid) begin
        chk("stall_hold_data", m_if.tdata, sd);
        chk("stall_hold_keep_last", {m_if.tkeep, m_if.tlast}, {sk, sl});
      end
      if (m_if.tvalid && m_if.tready) begin
        stall = 0;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got beat with empty scoreboard expected none");
        end else begin
          e = q.pop_front();
          if (m_if.tdata !== e.data || m_if.tkeep !== e.keep || m_if.tlast !== e.last ||
              m_if.tuser !== e.user) begin
            errors++;
            $display("FAIL out_beat: got keep=%0h last=%0b user=%0h data=%0h expected keep=%0h last=%0b user=%0h data=%0h",
                     m_if.tkeep, m_if.tlast, m_if.tuser, m_if.tdata, e.keep, e.last, e.user, e.data);
          end
          if (chk_lat) chk("latency", cyc, e.acc + 1);
          if (e.last)    exp_frame = exp_frame + 1;
          if (e.patched) exp_patch = exp_patch + 1;
        end
      end else if (m_if.tvalid) begin
        stall = 1; sd = m_if.tdata; sk = m_if.tkeep; sl = m_if.tlast;
      end else begin
        stall = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 0; s_if.tuser = '0;
    cfg_enable = 0; cfg_offset = '0; cfg_data = '0;
    @(negedge clk); #1;
    check_reset_outputs();
    release_reset();

    // single-byte patch in the middle of a 3-beat frame, latency 1
    cfg_enable = 1; cfg_offset = 16'h0045; cfg_data = 8'hAA; chk_lat = 1;
    send_frame(3, 0);
    drain();
    chk_lat = 0;
    chk("req025_patch_cnt", stat_patch_count, 1);
    chk("req025_frame_cnt", stat_frame_count, 1);

    // offset past frame end, then target lane not kept
    cfg_offset = 16'h0080;
    send_frame(2, 0);
    cfg_offset = 16'h003F;
    send(rnd_data(), 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
    drain();
    chk("req026_patch_cnt", stat_patch_count, 1);

    // backpressure 1,0,0,1 on a continuous 8-beat stream
    cfg_offset = 16'h0105; rdy_mode = 1; pidx = 0;
    send_frame(8, 0);
    drain();
    rdy_mode = 0;

    // cfg_data changes mid-frame only affects the next frame
    cfg_offset = 16'h008A; cfg_data = 8'h11;
    send(rnd_data(), {KW{1'b1}}, 1'b0, 1'b0);
    cfg_data = 8'h22;
    for (int b = 1; b < 4; b++) send(rnd_data(), {KW{1'b1}}, b == 3, 1'b0);
    send_frame(4, 0);
    drain();

    // reset in the middle of a 5-beat frame
    cfg_offset = 16'h0003; cfg_data = 8'h5C;
    send(rnd_data(), {KW{1'b1}}, 1'b0, 1'b0);
    send(rnd_data(), {KW{1'b1}}, 1'b0, 1'b0);
    s_if.tdata = rnd_data(); s_if.tkeep = {KW{1'b1}}; s_if.tlast = 0; s_if.tvalid = 1;
    #2;
    rst = 1'b1; chk_en = 0;
    q.delete(); in_frame = 0; bidx = 0; exp_frame = 0; exp_patch = 0;
    #1;
    check_reset_outputs();
    s_if.tvalid = 0;
    @(negedge clk);
    release_reset();
    send_frame(2, 0);
    drain();
    chk("req029_patch_cnt", stat_patch_count, 1);

    // patch beyond the saturation point is suppressed; just below it still patches
    cfg_offset = 16'hFFC5;
    send_frame(1030, 0);
    cfg_offset = 16'hFF87;
    send_frame(1030, 0);
    drain();
    chk("sat_patch_cnt", stat_patch_count, 2);

    // randomized frames with random config, keep, gaps and backpressure
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 6);
      cfg_enable = ($urandom_range(0, 3) != 0);
      cfg_offset = OW'($urandom_range(0, 7*64-1));
      cfg_data   = 8'($urandom);
      for (int b = 0; b < len; b++) begin
        send(rnd_data(), ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : {KW{1'b1}},
             b == len-1, UW'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          cfg_offset = OW'($urandom_range(0, 7*64-1));
          cfg_data   = 8'($urandom);
          cfg_enable = ~cfg_enable;
        end
        if ($urandom_range(0, 4) == 0) @(negedge clk);
      end
    end
    drain();
    rdy_mode = 0;

    // frame counter wraps modulo 2^32
    force dut.frame_cnt = 32'hFFFF_FFFF;
    exp_frame = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frame_cnt;
    send_frame(1, 0);
    drain();
    chk("req030_frame_wrap", stat_frame_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/kugelblitz_frame_patch.md
KUGELBLITZ_FRAME_PATCH -- requirements
Module: kugelblitz_frame_patch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: AXI stream data width in bits; only 512 is supported.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8: tkeep width; KEEP_WIDTH*8 != DATA_WIDTH is a configuration error.
REQ-003 SHALL have parameter USER_WIDTH, default 1: tuser width.
REQ-004 SHALL have parameter OFFSET_WIDTH, default 16: frame byte offset width.
REQ-005 SHALL have one clock and an asynchronous active-high reset:
- clk  in  1  sole clock; all flops on its rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have these ports (name, direction, width, meaning):
- s_axis_tdata  in  DATA_WIDTH  input beat data.
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  USER_WIDTH  sideband; passed through unmodified.
- m_axis_tdata/tkeep/tvalid/tlast/tuser  out  as s_axis  output beat.
- m_axis_tready  in  1  downstream ready.
- cfg_enable  in  1  patching enabled.
- cfg_offset  in  OFFSET_WIDTH  absolute frame byte offset to overwrite.
- cfg_data  in  8  replacement byte.
- stat_frame_count  out  32  frames passed (tlast beats output).
- stat_patch_count  out  32  bytes actually overwritten.

Function
REQ-007 SHALL be a registered pipeline stage: output register plus one skid register; latency 1 cycle from input acceptance to m_axis_tvalid when the output register is empty.
REQ-008 s_axis_tready SHALL be driven directly from a flop: high iff the skid register is empty.
REQ-009 SHALL sustain one beat per cycle while m_axis_tready is high; SHALL never drop, duplicate or reorder beats.
REQ-010 m_axis_* SHALL hold stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-011 SHALL track frames with a 2-state FSM:
- IDLE: next accepted beat is the first beat of a frame.
- FRAME: mid-frame.
REQ-012 FSM transitions:
- IDLE -> FRAME on an accepted beat with tlast=0.
- IDLE -> IDLE on an accepted beat with tlast=1 (single-beat frame).
- FRAME -> IDLE on an accepted beat with tlast=1.
- No transition without input acceptance.
REQ-013 On the first accepted beat (IDLE), cfg_enable, cfg_offset and cfg_data SHALL be latched and used for the whole frame; cfg changes mid-frame SHALL take effect only from the next frame.
REQ-014 The first-beat patch decision SHALL use the live cfg values.
REQ-015 A beat counter SHALL count beats within a frame:
- 0 on the first beat; +1 per accepted beat.
- cleared to 0 after an accepted tlast.
- saturates at 2^(OFFSET_WIDTH-6)-1 and does not wrap.
REQ-016 Patch rule, evaluated at input acceptance: the byte at lane cfg_offset[5:0] SHALL be replaced by cfg_data iff all hold:
- enable is 1;
- beat count == cfg_offset[OFFSET_WIDTH-1:6];
- tkeep at that lane is 1.
All other bytes, tkeep, tlast and tuser SHALL pass unchanged.
REQ-017 An offset beyond the frame end, or a target lane with tkeep=0, SHALL produce no patch and no stat_patch_count increment.
REQ-018 Once the beat counter is saturated, patching SHALL be suppressed for the remainder of the frame.
REQ-019 stat_frame_count SHALL increment on each output handshake with m_axis_tlast=1.
REQ-020 stat_patch_count SHALL increment on each output handshake of a patched beat.
REQ-021 Both statistics counters SHALL wrap modulo 2^32.

Reset
REQ-022 While rst is high, all of the following SHALL be forced immediately (asynchronously):
- m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tuser=0.
- s_axis_tready=0.
- skid register empty; FSM=IDLE; beat counter=0.
- stat_frame_count=0, stat_patch_count=0.
REQ-023 s_axis_tready SHALL rise on the first clk edge after rst deasserts.
REQ-024 A frame in flight at reset SHALL be discarded; the next accepted beat SHALL be treated as a first beat.

Verification
REQ-025 Bench: cfg_enable=1, cfg_offset=0x0045, cfg_data=0xAA, 3-beat full-keep frame, m_axis_tready=1 -> beat 1 byte 5 = 0xAA, all other bytes equal input; stat_patch_count=1, stat_frame_count=1; each beat emerges 1 cycle after acceptance.
REQ-026 Bench: cfg_offset=0x0080, 2-beat frame -> no patch; stat_patch_count=0. Then cfg_offset=0x003F with beat-0 tkeep=0x00000000FFFFFFFF -> no patch.
REQ-027 Bench: m_axis_tready toggles 1,0,0,1 during a continuous 8-beat stream -> s_axis_tready low only while the skid register is full; output equals input sequence with no loss.
REQ-028 Bench: cfg_data changes 0x11 -> 0x22 during beat 1 of a 4-beat frame targeting beat 2 -> patched byte is 0x11; the next frame uses 0x22.
REQ-029 Bench: assert rst mid-frame (beat 2 of 5) -> outputs zero immediately, counters 0; the next frame is patched using beat index 0 from its first beat.
REQ-030 Bench: preload stat_frame_count=0xFFFFFFFF via 2^32-1 frames (or forced), then one frame -> count reads 0.
